// File: rtl/vehicle_queue_sensor_if.sv
// Detector inputs, green indications and queue-status outputs of vehicle_queue_sensor.
// The master side drives the detectors and greens; the slave (the sensor) drives the status.
interface vehicle_queue_sensor_if #(
  parameter int CNT_W = 4
);
  logic             arr_NS, arr_SN, arr_EW, arr_WE;
  logic             dep_NS, dep_SN, dep_EW, dep_WE;
  logic             green_NS, green_SN, green_EW, green_WE;
  logic             S1_NS, S1_SN, S1_EW, S1_WE;
  logic             S5_NS, S5_SN, S5_EW, S5_WE;
  logic [CNT_W-1:0] queue_NS, queue_SN, queue_EW, queue_WE;
  logic             underflow;

  modport master (
    output arr_NS, arr_SN, arr_EW, arr_WE,
    output dep_NS, dep_SN, dep_EW, dep_WE,
    output green_NS, green_SN, green_EW, green_WE,
    input  S1_NS, S1_SN, S1_EW, S1_WE,
    input  S5_NS, S5_SN, S5_EW, S5_WE,
    input  queue_NS, queue_SN, queue_EW, queue_WE,
    input  underflow
  );

  modport slave (
    input  arr_NS, arr_SN, arr_EW, arr_WE,
    input  dep_NS, dep_SN, dep_EW, dep_WE,
    input  green_NS, green_SN, green_EW, green_WE,
    output S1_NS, S1_SN, S1_EW, S1_WE,
    output S5_NS, S5_SN, S5_EW, S5_WE,
    output queue_NS, queue_SN, queue_EW, queue_WE,
    output underflow
  );
endinterface

// File: rtl/vehicle_queue_sensor.sv
// Synchronizes and debounces loop detectors, then tracks a saturating vehicle queue per approach.
// Define QUEUE_GREEN_GATE_EN to count departures only while the approach is green.
module vehicle_queue_sensor #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 4,
  parameter int HI_THRESH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  vehicle_queue_sensor_if.slave bus
);
  localparam int N_APP = 4;
  localparam int N_DET = 2 * N_APP;
  localparam logic [3:0]       DB_LIM  = 4'(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] HI_LIM  = CNT_W'(HI_THRESH);

  // Detector index: 0..3 arrivals NS/SN/EW/WE, 4..7 departures in the same order.
  logic [N_DET-1:0] raw;
  assign raw = {bus.dep_WE, bus.dep_EW, bus.dep_SN, bus.dep_NS,
                bus.arr_WE, bus.arr_EW, bus.arr_SN, bus.arr_NS};

  logic [N_DET-1:0]            sync1_q, sync1_d, sync2_q, sync2_d;
  logic [N_DET-1:0]            db_q, db_d, prev_q, prev_d;
  logic [N_DET-1:0][3:0]       cnt_q, cnt_d;
  logic [N_APP-1:0][CNT_W-1:0] queue_q, queue_d;
  logic [N_APP-1:0]            s1_q, s1_d, s5_q, s5_d;
  logic                        underflow_q, underflow_d;

  logic [N_DET-1:0] evt;
  logic [N_APP-1:0] arr_evt, dep_evt;

  assign evt     = db_q & ~prev_q;
  assign arr_evt = evt[N_APP-1:0];

`ifdef QUEUE_GREEN_GATE_EN
  logic [N_APP-1:0] green;
  assign green   = {bus.green_WE, bus.green_EW, bus.green_SN, bus.green_NS};
  assign dep_evt = evt[N_DET-1:N_APP] & green;
`else
  assign dep_evt = evt[N_DET-1:N_APP];
`endif

  always_comb begin
    // NOTE: every variable assigned here gets a default first so no path can infer a latch.
    sync1_d     = raw;
    sync2_d     = sync1_q;
    prev_d      = db_q;
    db_d        = db_q;
    cnt_d       = cnt_q;
    queue_d     = queue_q;
    underflow_d = underflow_q;
    s1_d        = '0;
    s5_d        = '0;

    for (int i = 0; i < N_DET; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] + 4'd1 == DB_LIM) begin
          db_d[i]  = ~db_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end else begin
        cnt_d[i] = '0;
      end
    end

    // Coincident arrival and departure cancel, and never flag underflow.
    for (int a = 0; a < N_APP; a++) begin
      unique case ({arr_evt[a], dep_evt[a]})
        2'b10: if (queue_q[a] != CNT_MAX) queue_d[a] = queue_q[a] + CNT_W'(1);
        2'b01: begin
          if (queue_q[a] != '0) queue_d[a] = queue_q[a] - CNT_W'(1);
          else                  underflow_d = 1'b1;
        end
        default: ;
      endcase
      s1_d[a] = (queue_d[a] != '0);
      s5_d[a] = (queue_d[a] >= HI_LIM);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      db_q        <= '0;
      prev_q      <= '0;
      cnt_q       <= '0;
      queue_q     <= '0;
      s1_q        <= '0;
      s5_q        <= '0;
      underflow_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      db_q        <= db_d;
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
      queue_q     <= queue_d;
      s1_q        <= s1_d;
      s5_q        <= s5_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.queue_NS  = queue_q[0];
  assign bus.queue_SN  = queue_q[1];
  assign bus.queue_EW  = queue_q[2];
  assign bus.queue_WE  = queue_q[3];
  assign bus.S1_NS     = s1_q[0];
  assign bus.S1_SN     = s1_q[1];
  assign bus.S1_EW     = s1_q[2];
  assign bus.S1_WE     = s1_q[3];
  assign bus.S5_NS     = s5_q[0];
  assign bus.S5_SN     = s5_q[1];
  assign bus.S5_EW     = s5_q[2];
  assign bus.S5_WE     = s5_q[3];
  assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_vehicle_queue_sensor.sv
// Self-checking bench for vehicle_queue_sensor: vector table, corner sequences and a random run
// against a window-based reference model of the detector conditioning and queue rules.
module tb_vehicle_queue_sensor;
  localparam int DB   = 4;
  localparam int CW   = 4;
  localparam int HI   = 5;
  localparam int QMAX = (1 << CW) - 1;
  localparam int OW   = 9 + 4 * CW;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] arr, dep, green;   // bit 0 NS, 1 SN, 2 EW, 3 WE

  always #5 clk = ~clk;

  vehicle_queue_sensor_if #(.CNT_W(CW)) bus ();

  assign bus.arr_NS   = arr[0];
  assign bus.arr_SN   = arr[1];
  assign bus.arr_EW   = arr[2];
  assign bus.arr_WE   = arr[3];
  assign bus.dep_NS   = dep[0];
  assign bus.dep_SN   = dep[1];
  assign bus.dep_EW   = dep[2];
  assign bus.dep_WE   = dep[3];
  assign bus.green_NS = green[0];
  assign bus.green_SN = green[1];
  assign bus.green_EW = green[2];
  assign bus.green_WE = green[3];

  vehicle_queue_sensor #(.DB_CYCLES(DB), .CNT_W(CW), .HI_THRESH(HI)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a detector's debounced level is the value of the most recent run of DB
  // identical raw samples, seen two cycles late; an event is a debounced rise one cycle later.
  logic [DB+1:0] m_hist [8];
  logic [7:0]    m_db, m_db_prev;
  int            m_q [4];
  bit            m_uf;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_hist[i] = '0;
    m_db      = '0;
    m_db_prev = '0;
    for (int a = 0; a < 4; a++) m_q[a] = 0;
    m_uf = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] a_in, input logic [3:0] d_in, input logic [3:0] g_in);
    logic [7:0]    raw, ev;
    logic [DB-1:0] win;
    bit            ae, de;
    raw       = {d_in, a_in};
    ev        = m_db & ~m_db_prev;
    m_db_prev = m_db;
    for (int i = 0; i < 8; i++) begin
      m_hist[i] = {m_hist[i][DB:0], raw[i]};
      win       = m_hist[i][DB+1:2];
      if (&win)           m_db[i] = 1'b1;
      else if (win == '0) m_db[i] = 1'b0;
    end
    for (int ap = 0; ap < 4; ap++) begin
      ae = ev[ap];
`ifdef QUEUE_GREEN_GATE_EN
      de = ev[ap+4] && g_in[ap];
`else
      de = ev[ap+4];
`endif
      if (ae && !de) begin
        if (m_q[ap] < QMAX) m_q[ap]++;
      end else if (de && !ae) begin
        if (m_q[ap] > 0) m_q[ap]--;
        else             m_uf = 1'b1;
      end
    end
  endtask

  function automatic logic [3:0][CW-1:0] mkq(input int ns, input int sn, input int ew, input int we);
    logic [3:0][CW-1:0] q;
    q[0] = CW'(ns);
    q[1] = CW'(sn);
    q[2] = CW'(ew);
    q[3] = CW'(we);
    return q;
  endfunction

  function automatic logic [OW-1:0] pack_exp(input logic [3:0][CW-1:0] q, input bit uf);
    logic [3:0] s1, s5;
    for (int a = 0; a < 4; a++) begin
      s1[a] = (int'(q[a]) >= 1);
      s5[a] = (int'(q[a]) >= HI);
    end
    return {uf, s5, s1, q};
  endfunction

  function automatic logic [OW-1:0] model_pack();
    return pack_exp(mkq(m_q[0], m_q[1], m_q[2], m_q[3]), m_uf);
  endfunction

  function automatic logic [OW-1:0] dut_out();
    return {bus.underflow,
            bus.S5_WE, bus.S5_EW, bus.S5_SN, bus.S5_NS,
            bus.S1_WE, bus.S1_EW, bus.S1_SN, bus.S1_NS,
            bus.queue_WE, bus.queue_EW, bus.queue_SN, bus.queue_NS};
  endfunction

  // One clock edge; the model sees the same input values the DUT sampled.
  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge(arr, dep, green);
    #1;
  endtask

  task automatic pulse(input logic [3:0] a, input logic [3:0] d, input int hold, input int settle);
    arr = a;
    dep = d;
    repeat (hold) step();
    arr = '0;
    dep = '0;
    repeat (settle) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0]         arr;
    logic [3:0]         dep;
    int                 hold;
    logic [3:0][CW-1:0] exp_q;
    bit                 exp_uf;
  } vec_t;

  vec_t       vecs [12];
  logic [11:0] lvl;
  int          rem [12];

  initial begin
    vecs[0]  = '{arr: 4'h1, dep: 4'h0, hold: 3,  exp_q: mkq(0, 0, 0, 0), exp_uf: 1'b0};
    vecs[1]  = '{arr: 4'h1, dep: 4'h0, hold: 4,  exp_q: mkq(1, 0, 0, 0), exp_uf: 1'b0};
    vecs[2]  = '{arr: 4'h1, dep: 4'h0, hold: 10, exp_q: mkq(2, 0, 0, 0), exp_uf: 1'b0};
    vecs[3]  = '{arr: 4'h1, dep: 4'h0, hold: 6,  exp_q: mkq(3, 0, 0, 0), exp_uf: 1'b0};
    vecs[4]  = '{arr: 4'h1, dep: 4'h1, hold: 6,  exp_q: mkq(3, 0, 0, 0), exp_uf: 1'b0};
    vecs[5]  = '{arr: 4'h0, dep: 4'h1, hold: 6,  exp_q: mkq(2, 0, 0, 0), exp_uf: 1'b0};
    vecs[6]  = '{arr: 4'h0, dep: 4'h8, hold: 6,  exp_q: mkq(2, 0, 0, 0), exp_uf: 1'b1};
    vecs[7]  = '{arr: 4'hC, dep: 4'h0, hold: 6,  exp_q: mkq(2, 0, 1, 1), exp_uf: 1'b1};
    vecs[8]  = '{arr: 4'hF, dep: 4'h0, hold: 6,  exp_q: mkq(3, 1, 2, 2), exp_uf: 1'b1};
    vecs[9]  = '{arr: 4'h0, dep: 4'h6, hold: 6,  exp_q: mkq(3, 0, 1, 2), exp_uf: 1'b1};
    vecs[10] = '{arr: 4'h0, dep: 4'h1, hold: 3,  exp_q: mkq(3, 0, 1, 2), exp_uf: 1'b1};
    vecs[11] = '{arr: 4'h2, dep: 4'h4, hold: 5,  exp_q: mkq(3, 1, 0, 2), exp_uf: 1'b1};

    arr   = '0;
    dep   = '0;
    green = 4'hF;
    rst   = 1'b0;
    model_reset();

    // Reset with every detector active, then release with arrivals still held.
    rst = 1'b1;
    arr = 4'hF;
    dep = 4'hF;
    repeat (2) step();
    check("reset_outputs", dut_out(), '0);
    rst = 1'b0;
    dep = '0;
    for (int e = 1; e <= DB + 2; e++) begin
      step();
      check($sformatf("post_reset_edge%0d", e), dut_out(), '0);
    end
    step();
    check("arrival_latency", dut_out(), pack_exp(mkq(1, 1, 1, 1), 1'b0));
    arr = '0;
    repeat (12) step();

    // Vector table from a clean reset.
    do_reset();
    for (int v = 0; v < 12; v++) begin
      pulse(vecs[v].arr, vecs[v].dep, vecs[v].hold, 12);
      check($sformatf("vec_row%0d", v), dut_out(), pack_exp(vecs[v].exp_q, vecs[v].exp_uf));
    end

    // Bounce on arr_EW: runs of 3 synchronized cycles never debounce.
    for (int c = 0; c < 42; c++) begin
      arr[2] = ((c / 3) % 2 == 0);
      step();
    end
    arr = '0;
    repeat (12) step();
    check("bounce_queue_EW", bus.queue_EW, 0);

    // Threshold and saturation on SN.
    do_reset();
    for (int p = 1; p <= 20; p++) begin
      pulse(4'h2, 4'h0, 5, 10);
      check($sformatf("sat_queue_SN_p%0d", p), bus.queue_SN, (p < QMAX) ? p : QMAX);
      check($sformatf("sat_S5_SN_p%0d", p), bus.S5_SN, (p >= HI));
    end

    // Underflow is sticky until reset.
    do_reset();
    check("uf_clear", bus.underflow, 0);
    pulse(4'h0, 4'h8, 6, 12);
    check("uf_set", {bus.underflow, bus.queue_WE}, {1'b1, CW'(0)});
    pulse(4'h8, 4'h0, 6, 12);
    check("uf_sticky", {bus.underflow, bus.queue_WE}, {1'b1, CW'(1)});
    do_reset();
    check("uf_rst", bus.underflow, 0);

    // Green gating of departures on EW.
    do_reset();
    pulse(4'h4, 4'h0, 6, 12);
    pulse(4'h4, 4'h0, 6, 12);
    check("gate_setup", bus.queue_EW, 2);
    green = 4'hB;
    pulse(4'h0, 4'h4, 6, 12);
`ifdef QUEUE_GREEN_GATE_EN
    check("gate_red_dep", {bus.underflow, bus.queue_EW}, {1'b0, CW'(2)});
`else
    check("gate_red_dep", {bus.underflow, bus.queue_EW}, {1'b0, CW'(1)});
`endif
    green = 4'hF;
    pulse(4'h0, 4'h4, 6, 12);
`ifdef QUEUE_GREEN_GATE_EN
    check("gate_green_dep", bus.queue_EW, 1);
`else
    check("gate_green_dep", bus.queue_EW, 0);
`endif

    // Random levels with random hold lengths, occasional resets, compared every cycle.
    do_reset();
    lvl = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int j = 0; j < 12; j++) begin
        if (rem[j] == 0) begin
          lvl[j] = 1'($urandom_range(0, 1));
          rem[j] = $urandom_range(1, 10);
        end
        rem[j]--;
      end
      arr   = lvl[3:0];
      dep   = lvl[7:4];
      green = lvl[11:8];
      rst   = ($urandom_range(0, 599) == 0);
      step();
      check($sformatf("rand_cyc%0d", c), dut_out(), model_pack());
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
